perf_counter_bank: RTL and testbench

- Parametrised Avalon-MM performance-counter slave, next generation of the system's fixed six-section counter.
- Each section has a time counter (clock cycles while running) and an event counter (start writes); software brackets code regions with start/stop writes.
- Adds over the fixed block: configurable section count and widths, coherent 64-bit time reads via high-word snapshot, sticky overflow flags, per-section clear, and a global freeze/clear control register.
- Sits on the CPU data master's Avalon bus, clocked by the system clock.

---
 rtl/perf_counter_bank.sv | 194 +++++++++++++++++++
 tb/tb_perf_counter_bank.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// Avalon-MM performance counter bank: per-section cycle/event counters with
// sticky overflow flags, coherent 64-bit time reads and a global freeze/clear.

module perf_section #(
    parameter int TIME_W  = 48,
    parameter int EVENT_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        freeze,
    input  logic        global_clr,
    input  logic        wr_stop,
    input  logic        wr_start,
    input  logic        wr_status,
    input  logic        snap,
    input  logic [2:0]  wr_bits,
    input  logic [1:0]  offset,
    output logic [31:0] rdata
);

    logic                 enable;
    logic                 time_ovf;
    logic                 event_ovf;
    logic [TIME_W-1:0]    time_cnt;
    logic [EVENT_W-1:0]   event_cnt;
    logic [TIME_W-33:0]   hi_shadow;

    logic sec_clr;
    logic time_inc;
    logic time_wrap;
    logic event_inc;
    logic event_wrap;

    assign sec_clr    = global_clr | (wr_stop & wr_bits[0]);
    assign time_inc   = enable & ~freeze;
    assign time_wrap  = time_inc & (&time_cnt);
    assign event_inc  = wr_start & ~freeze;
    assign event_wrap = event_inc & (&event_cnt);

    // Clears win over increments; a wrap in the same cycle as a W1C keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable    <= 1'b0;
            time_cnt  <= '0;
            event_cnt <= '0;
            time_ovf  <= 1'b0;
            event_ovf <= 1'b0;
        end else if (sec_clr) begin
            enable    <= 1'b0;
            time_cnt  <= '0;
            event_cnt <= '0;
            time_ovf  <= 1'b0;
            event_ovf <= 1'b0;
        end else begin
            if (wr_stop) begin
                enable <= 1'b0;
            end else if (wr_start) begin
                enable <= 1'b1;
            end

            if (time_inc) begin
                time_cnt <= time_cnt + 1'b1;
            end

            if (event_inc) begin
                event_cnt <= event_cnt + 1'b1;
            end

            if (time_wrap) begin
                time_ovf <= 1'b1;
            end else if (wr_status && wr_bits[1]) begin
                time_ovf <= 1'b0;
            end

            if (event_wrap) begin
                event_ovf <= 1'b1;
            end else if (wr_status && wr_bits[2]) begin
                event_ovf <= 1'b0;
            end
        end
    end

    // High word is captured on the low-word read so the pair reads coherently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_shadow <= '0;
        end else if (snap) begin
            hi_shadow <= time_cnt[TIME_W-1:32];
        end
    end

    always_comb begin
        rdata = '0;
        case (offset)
            2'd0:    rdata = time_cnt[31:0];
            2'd1:    rdata = 32'(hi_shadow);
            2'd2:    rdata = 32'(event_cnt);
            default: rdata = {29'b0, event_ovf, time_ovf, enable};
        endcase
    end

endmodule

module perf_counter_bank #(
    parameter int NUM_SECTIONS = 4,
    parameter int TIME_W       = 48,
    parameter int EVENT_W      = 32,
    parameter int ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              begintransfer,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata
);

    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(4 * NUM_SECTIONS);

    logic                    wr_stb;
    logic                    rd_stb;
    logic                    ctrl_hit;
    logic                    global_clr;
    logic                    freeze;
    logic [ADDR_W-3:0]       sec_idx;
    logic [1:0]              offset;
    logic [NUM_SECTIONS-1:0] sec_sel;
    logic [31:0]             sec_rdata [NUM_SECTIONS];
    logic [31:0]             rd_next;
    logic                    unused_wdata;

    assign wr_stb       = write & begintransfer;
    assign rd_stb       = read & begintransfer;
    assign sec_idx      = address[ADDR_W-1:2];
    assign offset       = address[1:0];
    assign ctrl_hit     = (address == CTRL_ADDR);
    assign global_clr   = wr_stb & ctrl_hit & writedata[0];
    assign unused_wdata = ^writedata[31:3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            freeze <= 1'b0;
        end else if (wr_stb && ctrl_hit) begin
            freeze <= writedata[1];
        end
    end

    for (genvar s = 0; s < NUM_SECTIONS; s++) begin : g_sec
        logic sel;

        assign sel        = (sec_idx == (ADDR_W-2)'(s));
        assign sec_sel[s] = sel;

        perf_section #(
            .TIME_W  (TIME_W),
            .EVENT_W (EVENT_W)
        ) u_sec (
            .clk        (clk),
            .reset_n    (reset_n),
            .freeze     (freeze),
            .global_clr (global_clr),
            .wr_stop    (wr_stb & sel & (offset == 2'd0)),
            .wr_start   (wr_stb & sel & (offset == 2'd1)),
            .wr_status  (wr_stb & sel & (offset == 2'd3)),
            .snap       (rd_stb & sel & (offset == 2'd0)),
            .wr_bits    (writedata[2:0]),
            .offset     (offset),
            .rdata      (sec_rdata[s])
        );
    end

    always_comb begin
        rd_next = '0;
        if (ctrl_hit) begin
            rd_next = {30'b0, freeze, 1'b0};
        end
        for (int i = 0; i < NUM_SECTIONS; i++) begin
            if (sec_sel[i]) begin
                rd_next = sec_rdata[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank (4 sections, 48-bit time, 4-bit events).

module tb_perf_counter_bank;

    logic        clk;
    logic        reset_n;
    logic [5:0]  address;
    logic        begintransfer;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    int errors = 0;
    int checks = 0;

    perf_counter_bank #(
        .NUM_SECTIONS (4),
        .TIME_W       (48),
        .EVENT_W      (4),
        .ADDR_W       (6)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .begintransfer (begintransfer),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input int addr, input logic [31:0] data);
        address       = addr[5:0];
        writedata     = data;
        write         = 1'b1;
        begintransfer = 1'b1;
        @(posedge clk);
        @(negedge clk);
        write         = 1'b0;
        begintransfer = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int addr, input logic [31:0] exp);
        address       = addr[5:0];
        read          = 1'b1;
        begintransfer = 1'b1;
        @(posedge clk);
        @(negedge clk);
        read          = 1'b0;
        begintransfer = 1'b0;
        chk(tag, readdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        address       = '0;
        begintransfer = 1'b0;
        read          = 1'b0;
        write         = 1'b0;
        writedata     = '0;
        repeat (3) @(negedge clk);
        chk("rst_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Every mapped address plus one unmapped one reads zero out of reset
        for (int a = 0; a <= 16; a++) begin
            read_chk($sformatf("rst_addr%0d", a), a, 32'h0);
        end
        read_chk("unmapped17", 17, 32'h0);

        // Section 1: START, 10 idle cycles, STOP -> 11 cycles, 1 event
        bus_write(5, 32'h0);
        repeat (10) @(negedge clk);
        bus_write(4, 32'h0);
        read_chk("s1_time", 4, 32'd11);
        read_chk("s1_event", 6, 32'd1);
        read_chk("s1_status", 7, 32'h0);
        read_chk("s0_time_idle", 0, 32'h0);
        read_chk("s2_time_idle", 8, 32'h0);
        read_chk("s2_event_idle", 10, 32'h0);

        // Section 2: time wrap at 48 bits sets the sticky flag
        bus_write(9, 32'h0);
        force dut.g_sec[2].u_sec.time_cnt = 48'h0000_FFFF_FFFF_FFFE;
        #1;
        release dut.g_sec[2].u_sec.time_cnt;
        repeat (3) @(negedge clk);
        read_chk("s2_wrap_lo", 8, 32'h1);
        read_chk("s2_wrap_hi", 9, 32'h0);
        read_chk("s2_status_ovf", 11, 32'h3);
        bus_write(11, 32'h2);
        read_chk("s2_status_w1c", 11, 32'h1);

        // Section 0: high word comes from the shadow, not the live counter
        bus_write(1, 32'h0);
        force dut.g_sec[0].u_sec.time_cnt = 48'h0000_FFFF_FFFF;
        #1;
        release dut.g_sec[0].u_sec.time_cnt;
        read_chk("snap_lo", 0, 32'hFFFF_FFFF);
        read_chk("snap_hi_stale", 1, 32'h0);
        read_chk("snap_lo2", 0, 32'h0000_0001);
        read_chk("snap_hi2", 1, 32'h1);

        // Freeze holds time and events; unfreeze resumes on the next cycle
        bus_write(0, 32'h1);
        read_chk("s0_clr_time", 0, 32'h0);
        bus_write(1, 32'h0);
        bus_write(16, 32'h2);
        read_chk("frz_time_a", 0, 32'd1);
        repeat (20) @(negedge clk);
        read_chk("frz_time_b", 0, 32'd1);
        bus_write(1, 32'h0);
        read_chk("frz_event", 2, 32'd1);
        read_chk("frz_ctrl", 16, 32'h2);
        bus_write(16, 32'h0);
        read_chk("unfrz_time_a", 0, 32'd1);
        read_chk("unfrz_time_b", 0, 32'd2);
        read_chk("unfrz_ctrl", 16, 32'h0);

        // Section 3: 16 STARTs wrap the 4-bit event counter
        for (int i = 0; i < 16; i++) bus_write(13, 32'h0);
        read_chk("s3_event_wrap1", 14, 32'h0);
        read_chk("s3_status_wrap1", 15, 32'h5);

        // Global clear together with freeze
        bus_write(16, 32'h3);
        read_chk("gclr_ctrl", 16, 32'h2);
        read_chk("gclr_s0_time", 0, 32'h0);
        read_chk("gclr_s0_event", 2, 32'h0);
        read_chk("gclr_s0_status", 3, 32'h0);
        read_chk("gclr_s2_time", 8, 32'h0);
        read_chk("gclr_s2_status", 11, 32'h0);
        read_chk("gclr_s3_event", 14, 32'h0);
        read_chk("gclr_s3_status", 15, 32'h0);
        bus_write(16, 32'h0);
        read_chk("gclr_s0_stays", 0, 32'h0);

        // Event boundary: 15 then wrap to 0 on the 16th
        for (int i = 0; i < 15; i++) bus_write(13, 32'h0);
        read_chk("s3_event_15", 14, 32'hF);
        read_chk("s3_status_15", 15, 32'h1);
        bus_write(13, 32'h0);
        read_chk("s3_event_wrap2", 14, 32'h0);
        read_chk("s3_status_wrap2", 15, 32'h5);
        bus_write(15, 32'h4);
        read_chk("s3_status_w1c", 15, 32'h1);
        bus_write(12, 32'h1);
        read_chk("s3_status_stopclr", 15, 32'h0);
        read_chk("s1_untouched", 6, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
